// File: rtl/reorder_buffer_pkg.sv
// Shared widths, constants and entry layout for the reorder buffer and its
// operand lookup.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;

  typedef logic [TAG_W-1:0]  rob_bus_t;
  typedef logic [DATA_W-1:0] data_bus_t;

  localparam logic      Enable  = 1'b1;
  localparam logic      Disable = 1'b0;
  localparam data_bus_t Null    = '0;

  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(ROB_DEPTH);

  // Dispatch fills rd/pc/flags; the CDB fills value/taken/target.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    data_bus_t        pc;
    data_bus_t        value;
    logic             is_store;
    logic             is_branch;
    logic             pred_taken;
    logic             taken;
    data_bus_t        target;
  } rob_entry_t;

  function automatic data_bus_t redirect_pc(input rob_entry_t e);
    return e.taken ? e.target : e.pc + DATA_W'(4);
  endfunction

endpackage

// File: rtl/reorder_buffer_operand_lookup.sv
// Combinational tag -> (already, value) lookup with a bypass from the CDB
// result being broadcast in the same cycle.
module rob_operand_lookup
  import reorder_buffer_pkg::*;
(
  input  logic [TAG_W-1:0]                 tag_i,
  input  logic [ROB_DEPTH-1:0]             busy_i,
  input  logic [ROB_DEPTH-1:0]             ready_i,
  input  logic [ROB_DEPTH-1:0][DATA_W-1:0] value_i,
  input  logic                             cdb_en_i,
  input  logic [TAG_W-1:0]                 cdb_tag_i,
  input  logic [DATA_W-1:0]                cdb_value_i,
  output logic                             already_o,
  output logic [DATA_W-1:0]                value_o
);

  logic cdb_hit;
  logic ent_hit;

  assign cdb_hit   = cdb_en_i && (cdb_tag_i == tag_i);
  assign ent_hit   = busy_i[tag_i] && ready_i[tag_i];
  assign already_o = cdb_hit || ent_hit;
  assign value_o   = cdb_hit ? cdb_value_i : (ent_hit ? value_i[tag_i] : Null);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at dispatch, captures CDB results,
// retires one entry per cycle and flushes on a committed branch mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              dispatch_en,
  input  logic [4:0]        dispatch_rd,
  input  logic [31:0]       dispatch_pc,
  input  logic              dispatch_is_store,
  input  logic              dispatch_is_branch,
  input  logic              dispatch_pred_taken,
  output logic [TAG_W-1:0]  nxt_pos,
  output logic              full,
  input  logic [TAG_W-1:0]  rs1_reorder,
  input  logic [TAG_W-1:0]  rs2_reorder,
  output logic              rs1_already,
  output logic              rs2_already,
  output logic [31:0]       rs1_value,
  output logic [31:0]       rs2_value,
  input  logic              cdb_en,
  input  logic [TAG_W-1:0]  cdb_reorder,
  input  logic [31:0]       cdb_value,
  input  logic              cdb_taken,
  input  logic [31:0]       cdb_target,
  output logic              commit_en,
  output logic [4:0]        commit_rd,
  output logic [31:0]       commit_value,
  output logic [TAG_W-1:0]  commit_reorder,
  output logic              store_commit,
  output logic [TAG_W-1:0]  store_reorder,
  output logic              flush,
  output logic [31:0]       flush_pc
);

  rob_entry_t                       ent_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0]             busy_q, ready_q;
  logic [ROB_DEPTH-1:0][DATA_W-1:0] val_vec;
  logic [TAG_W-1:0]                 head_q, tail_q;
  logic [TAG_W:0]                   count_q;

  logic              commit_en_q, store_commit_q, flush_q;
  logic [REG_W-1:0]  commit_rd_q;
  data_bus_t         commit_value_q, flush_pc_q;
  logic [TAG_W-1:0]  commit_reorder_q, store_reorder_q;

  rob_entry_t head_ent;
  logic       retire, mispredict, do_disp, do_cdb;

  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) val_vec[i] = ent_q[i].value;
  end

  assign full     = (count_q == CNT_FULL);
  assign nxt_pos  = tail_q;
  assign head_ent = ent_q[head_q];

  // Full uses the pre-edge count, so a retiring slot is not reusable this cycle.
  assign retire     = rdy_in && (count_q != '0) && ready_q[head_q];
  assign mispredict = retire && head_ent.is_branch && (head_ent.taken != head_ent.pred_taken);
  assign do_disp    = rdy_in && dispatch_en && !full && !mispredict && !flush_q;
  assign do_cdb     = rdy_in && cdb_en && busy_q[cdb_reorder] && !mispredict;

  rob_operand_lookup u_rs1 (
    .tag_i(rs1_reorder), .busy_i(busy_q), .ready_i(ready_q), .value_i(val_vec),
    .cdb_en_i(cdb_en), .cdb_tag_i(cdb_reorder), .cdb_value_i(cdb_value),
    .already_o(rs1_already), .value_o(rs1_value)
  );

  rob_operand_lookup u_rs2 (
    .tag_i(rs2_reorder), .busy_i(busy_q), .ready_i(ready_q), .value_i(val_vec),
    .cdb_en_i(cdb_en), .cdb_tag_i(cdb_reorder), .cdb_value_i(cdb_value),
    .already_o(rs2_already), .value_o(rs2_value)
  );

  always_ff @(posedge clk_in) begin
    if (do_disp) begin
      ent_q[tail_q].rd         <= dispatch_rd;
      ent_q[tail_q].pc         <= dispatch_pc;
      ent_q[tail_q].is_store   <= dispatch_is_store;
      ent_q[tail_q].is_branch  <= dispatch_is_branch;
      ent_q[tail_q].pred_taken <= dispatch_pred_taken;
    end
    if (do_cdb) begin
      ent_q[cdb_reorder].value  <= cdb_value;
      ent_q[cdb_reorder].taken  <= cdb_taken;
      ent_q[cdb_reorder].target <= cdb_target;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      busy_q           <= '0;
      ready_q          <= '0;
      commit_en_q      <= Disable;
      store_commit_q   <= Disable;
      flush_q          <= Disable;
      commit_rd_q      <= '0;
      commit_value_q   <= Null;
      commit_reorder_q <= '0;
      store_reorder_q  <= '0;
      flush_pc_q       <= Null;
    end else if (!rdy_in) begin
      commit_en_q    <= Disable;
      store_commit_q <= Disable;
      flush_q        <= Disable;
    end else begin
      commit_en_q    <= retire && !head_ent.is_store && (head_ent.rd != '0);
      store_commit_q <= retire && head_ent.is_store;
      flush_q        <= mispredict;
      if (retire) begin
        commit_rd_q      <= head_ent.rd;
        commit_value_q   <= head_ent.value;
        commit_reorder_q <= head_q;
        store_reorder_q  <= head_q;
      end
      if (mispredict) begin
        flush_pc_q <= redirect_pc(head_ent);
        busy_q     <= '0;
        ready_q    <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
      end else begin
        head_q  <= head_q + TAG_W'(retire);
        tail_q  <= tail_q + TAG_W'(do_disp);
        count_q <= count_q + (TAG_W+1)'(do_disp) - (TAG_W+1)'(retire);
        if (retire) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
        end
        if (do_disp) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
        end
        if (do_cdb) ready_q[cdb_reorder] <= 1'b1;
      end
    end
  end

  assign commit_en      = commit_en_q;
  assign commit_rd      = commit_rd_q;
  assign commit_value   = commit_value_q;
  assign commit_reorder = commit_reorder_q;
  assign store_commit   = store_commit_q;
  assign store_reorder  = store_reorder_q;
  assign flush          = flush_q;
  assign flush_pc       = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a cycle table for in-order retirement
// plus hand sequences for full/wrap, bypass, flush, store, pause and reset.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        dispatch_en, dispatch_is_store, dispatch_is_branch, dispatch_pred_taken;
  logic [4:0]  dispatch_rd;
  logic [31:0] dispatch_pc;
  logic [3:0]  nxt_pos, rs1_reorder, rs2_reorder, cdb_reorder, commit_reorder, store_reorder;
  logic        full, rs1_already, rs2_already, cdb_en, cdb_taken;
  logic [31:0] rs1_value, rs2_value, cdb_value, cdb_target, commit_value, flush_pc;
  logic        commit_en, store_commit, flush;
  logic [4:0]  commit_rd;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dispatch_en(dispatch_en), .dispatch_rd(dispatch_rd), .dispatch_pc(dispatch_pc),
    .dispatch_is_store(dispatch_is_store), .dispatch_is_branch(dispatch_is_branch),
    .dispatch_pred_taken(dispatch_pred_taken), .nxt_pos(nxt_pos), .full(full),
    .rs1_reorder(rs1_reorder), .rs2_reorder(rs2_reorder),
    .rs1_already(rs1_already), .rs2_already(rs2_already),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .cdb_en(cdb_en), .cdb_reorder(cdb_reorder), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_reorder(commit_reorder), .store_commit(store_commit),
    .store_reorder(store_reorder), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        d_en;
    logic [4:0]  d_rd;
    logic        c_en;
    logic [3:0]  c_tag;
    logic [31:0] c_val;
    logic [3:0]  rs1;
    logic [3:0]  e_nxt;
    logic        e_cen;
    logic [4:0]  e_crd;
    logic [31:0] e_cval;
    logic        e_a;
    logic [31:0] e_v;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic d_en, logic [4:0] d_rd, logic c_en, logic [3:0] c_tag,
                              logic [31:0] c_val, logic [3:0] rs1, logic [3:0] e_nxt,
                              logic e_cen, logic [4:0] e_crd, logic [31:0] e_cval,
                              logic e_a, logic [31:0] e_v);
    vec_t v;
    v.d_en = d_en; v.d_rd = d_rd; v.c_en = c_en; v.c_tag = c_tag; v.c_val = c_val;
    v.rs1 = rs1; v.e_nxt = e_nxt; v.e_cen = e_cen; v.e_crd = e_crd; v.e_cval = e_cval;
    v.e_a = e_a; v.e_v = e_v;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1;
    dispatch_en = 1'b0; dispatch_rd = '0; dispatch_pc = '0;
    dispatch_is_store = 1'b0; dispatch_is_branch = 1'b0; dispatch_pred_taken = 1'b0;
    cdb_en = 1'b0; cdb_reorder = '0; cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
    rs1_reorder = '0; rs2_reorder = '0;
  endtask

  task automatic nxt();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    nxt();
  endtask

  task automatic disp(input logic [4:0] rd, input logic [31:0] pc, input logic st,
                      input logic br, input logic pred);
    dispatch_en = 1'b1; dispatch_rd = rd; dispatch_pc = pc;
    dispatch_is_store = st; dispatch_is_branch = br; dispatch_pred_taken = pred;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input logic tk,
                     input logic [31:0] tgt);
    cdb_en = 1'b1; cdb_reorder = tag; cdb_value = val; cdb_taken = tk; cdb_target = tgt;
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    nxt();
    rst_in = 1'b1;
    nxt();

    // d_en rd c_en tag val rs1 | nxt cen crd cval a v
    tbl[0]  = mk(0, 0, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0,     0, 0, 0, 0, 0,     0, 0);
    tbl[2]  = mk(1, 2, 0, 0, 0,     0, 1, 0, 0, 0,     0, 0);
    tbl[3]  = mk(1, 3, 0, 0, 0,     0, 2, 0, 0, 0,     0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 'h55,  1, 3, 0, 0, 0,     1, 'h55);
    tbl[5]  = mk(0, 0, 1, 0, 'h11,  1, 3, 0, 0, 0,     1, 'h55);
    tbl[6]  = mk(0, 0, 0, 0, 0,     0, 3, 0, 0, 0,     1, 'h11);
    tbl[7]  = mk(0, 0, 0, 0, 0,     0, 3, 1, 1, 'h11,  0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0,     2, 3, 1, 2, 'h55,  0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0,     2, 3, 0, 0, 0,     0, 0);
    tbl[10] = mk(0, 0, 1, 2, 'h33,  2, 3, 0, 0, 0,     1, 'h33);
    tbl[11] = mk(0, 0, 0, 0, 0,     2, 3, 0, 0, 0,     1, 'h33);
    tbl[12] = mk(0, 0, 0, 0, 0,     2, 3, 1, 3, 'h33,  0, 0);

    chk("reset_full", full, 0);
    chk("reset_store_commit", store_commit, 0);
    chk("reset_flush", flush, 0);
    chk("reset_flush_pc", flush_pc, 0);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].d_en) disp(tbl[i].d_rd, 32'(tbl[i].d_rd) * 4, 0, 0, 0);
      if (tbl[i].c_en) cdb(tbl[i].c_tag, tbl[i].c_val, 0, 0);
      rs1_reorder = tbl[i].rs1;
      #1;
      chk($sformatf("row%0d_nxt_pos", i), nxt_pos, tbl[i].e_nxt);
      chk($sformatf("row%0d_commit_en", i), commit_en, tbl[i].e_cen);
      if (tbl[i].e_cen) begin
        chk($sformatf("row%0d_commit_rd", i), commit_rd, tbl[i].e_crd);
        chk($sformatf("row%0d_commit_value", i), commit_value, tbl[i].e_cval);
      end
      chk($sformatf("row%0d_rs1_already", i), rs1_already, tbl[i].e_a);
      chk($sformatf("row%0d_rs1_value", i), rs1_value, tbl[i].e_v);
      nxt();
    end

    // Fill, drop while full (including a same-cycle retire), then wrap to tag 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp(5'(i + 1), 32'(i * 4), 0, 0, 0);
      nxt();
    end
    #1;
    chk("fill_full", full, 1);
    chk("fill_nxt_pos", nxt_pos, 0);
    disp(99, 'h999, 0, 0, 0); cdb(0, 'h77, 0, 0);
    nxt();
    disp(98, 'h998, 0, 0, 0);
    #1;
    chk("drop_full", full, 1);
    chk("drop_nxt_pos", nxt_pos, 0);
    nxt();
    disp(5, 'h40, 0, 0, 0);
    #1;
    chk("wrap_commit_en", commit_en, 1);
    chk("wrap_commit_rd", commit_rd, 1);
    chk("wrap_commit_value", commit_value, 'h77);
    chk("wrap_full_freed", full, 0);
    chk("wrap_nxt_pos", nxt_pos, 0);
    nxt();
    #1;
    chk("wrap_nxt_pos_after", nxt_pos, 1);
    chk("wrap_full_again", full, 1);

    // Same-cycle CDB bypass on the operand lookup.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      disp(5'(i + 1), 0, 0, 0, 0);
      nxt();
    end
    rs1_reorder = 4; rs2_reorder = 3; cdb(4, 'hABCD, 0, 0);
    #1;
    chk("byp_rs1_already", rs1_already, 1);
    chk("byp_rs1_value", rs1_value, 'hABCD);
    chk("byp_rs2_already", rs2_already, 0);
    chk("byp_rs2_value", rs2_value, 0);
    nxt();
    rs2_reorder = 4;
    #1;
    chk("stored_rs2_already", rs2_already, 1);
    chk("stored_rs2_value", rs2_value, 'hABCD);

    // Taken mispredict flushes; the younger ready entry never commits.
    do_reset();
    disp(0, 'h100, 0, 1, 0); nxt();
    disp(7, 'h104, 0, 0, 0); nxt();
    cdb(1, 9, 0, 0); nxt();
    cdb(0, 0, 1, 'h200); nxt();
    #1;
    chk("br_no_flush_yet", flush, 0);
    nxt();
    rs1_reorder = 1;
    #1;
    chk("br_flush", flush, 1);
    chk("br_flush_pc", flush_pc, 'h200);
    chk("br_commit_en_rd0", commit_en, 0);
    chk("br_nxt_pos", nxt_pos, 0);
    chk("br_rs1_cleared", rs1_already, 0);
    nxt();
    #1;
    chk("br_flush_drop", flush, 0);
    chk("br_young_c1", commit_en, 0);
    nxt();
    #1;
    chk("br_young_c2", commit_en, 0);

    // Not-taken mispredict of a linking branch: redirect pc+4, commit still issued.
    do_reset();
    disp(4, 'h300, 0, 1, 1); nxt();
    cdb(0, 'h304, 0, 'h999); nxt();
    nxt();
    #1;
    chk("nt_flush", flush, 1);
    chk("nt_flush_pc", flush_pc, 'h304);
    chk("nt_commit_en", commit_en, 1);
    chk("nt_commit_rd", commit_rd, 4);

    // Correctly predicted branch retires without a flush.
    do_reset();
    disp(0, 'h400, 0, 1, 1); nxt();
    cdb(0, 0, 1, 'h500); nxt();
    nxt();
    #1;
    chk("ok_br_flush", flush, 0);

    // rd=0 op, store, then ALU op.
    do_reset();
    disp(0, 0, 0, 0, 0); nxt();
    disp(0, 4, 1, 0, 0); nxt();
    disp(6, 8, 0, 0, 0); nxt();
    cdb(0, 'h1, 0, 0); nxt();
    cdb(1, 'h2, 0, 0); nxt();
    cdb(2, 'h66, 0, 0);
    #1;
    chk("rd0_commit_en", commit_en, 0);
    chk("rd0_store_commit", store_commit, 0);
    nxt();
    #1;
    chk("st_store_commit", store_commit, 1);
    chk("st_store_reorder", store_reorder, 1);
    chk("st_commit_en", commit_en, 0);
    nxt();
    #1;
    chk("alu_commit_en", commit_en, 1);
    chk("alu_commit_rd", commit_rd, 6);
    chk("alu_commit_value", commit_value, 'h66);
    chk("alu_commit_reorder", commit_reorder, 2);
    chk("alu_store_commit", store_commit, 0);

    // Pause holds everything, then operation resumes.
    do_reset();
    disp(8, 0, 0, 0, 0); nxt();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0;
      disp(9, 4, 0, 0, 0); cdb(0, 'hEE, 0, 0);
      #1;
      chk($sformatf("pause%0d_nxt_pos", i), nxt_pos, 1);
      chk($sformatf("pause%0d_commit_en", i), commit_en, 0);
      nxt();
    end
    rs1_reorder = 0;
    #1;
    chk("resume_rs1_already", rs1_already, 0);
    chk("resume_commit_en", commit_en, 0);
    cdb(0, 'h42, 0, 0);
    nxt();
    nxt();
    #1;
    chk("resume_commit_en2", commit_en, 1);
    chk("resume_commit_value", commit_value, 'h42);
    chk("resume_nxt_pos", nxt_pos, 1);

    // Reset on the retire edge drops the pending pulse.
    do_reset();
    disp(9, 0, 0, 0, 0); nxt();
    cdb(0, 'h5, 0, 0); nxt();
    rst_in = 1'b1;
    nxt();
    #1;
    chk("rst_mid_commit_en", commit_en, 0);
    chk("rst_mid_nxt_pos", nxt_pos, 0);
    chk("rst_mid_commit_rd", commit_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
